// File: rtl/iaxi_fetch_bridge.sv
// rtl/iaxi_fetch_bridge.sv - IAXI instruction-fetch port to single-beat AXI4 read bridge
// One fetch in flight; responses for an abandoned fetch address are drained and discarded.
module iaxi_fetch_bridge #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [3:0]  AXI_ID     = 4'h0,
  parameter logic [2:0]  AXI_PROT   = 3'b100
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  IAXI_access,
  input  logic [ADDR_WIDTH-1:0] IAXI_addr,
  output logic [DATA_WIDTH-1:0] IAXI_read_data,
  output logic                  IAXI_read_data_valid,
  output logic                  IAXI_bus_error,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [3:0]            M_ARID,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic [2:0]            M_ARPROT,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [3:0]            M_RID,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST
);

  typedef enum logic [1:0] {IDLE, AR, R, DROP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;
  logic                  redirect;
  logic                  resp_err;

  // The core has moved on if it stops requesting or points at a different word.
  assign redirect = !IAXI_access || ((IAXI_addr & ADDR_MASK) != req_addr_q);
  assign resp_err = (M_RRESP != 2'b00) || (M_RID != AXI_ID) || !M_RLAST;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    drop_d     = drop_q;
    case (state_q)
      // Skipping the pulse cycle gives the fetch unit a cycle to advance the pc.
      IDLE: if (IAXI_access && !valid_q) begin
        req_addr_d = IAXI_addr & ADDR_MASK;
        drop_d     = 1'b0;
        state_d    = AR;
      end
      AR: begin
        drop_d = drop_q || redirect;
        if (M_ARREADY) state_d = (drop_q || redirect) ? DROP : R;
      end
      R: begin
        if (M_RVALID) begin
          state_d = IDLE;
          if (!redirect) begin
            valid_d = 1'b1;
            err_d   = resp_err;
            rdata_d = M_RDATA;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: if (M_RVALID) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign M_ARVALID            = (state_q == AR);
  assign M_ARADDR             = req_addr_q;
  assign M_ARID               = AXI_ID;
  assign M_ARLEN              = 8'd0;
  assign M_ARSIZE             = 3'b010;
  assign M_ARBURST            = 2'b01;
  assign M_ARPROT             = AXI_PROT;
  assign M_RREADY             = (state_q == R) || (state_q == DROP);
  assign IAXI_read_data       = rdata_q;
  assign IAXI_read_data_valid = valid_q;
  assign IAXI_bus_error       = err_q;

endmodule

// File: tb/tb_iaxi_fetch_bridge.sv
// tb/tb_iaxi_fetch_bridge.sv - self-checking bench for iaxi_fetch_bridge
// Transaction-level model compared every cycle, directed scenarios, then random traffic.
module tb_iaxi_fetch_bridge;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        IAXI_access = 1'b0;
  logic [31:0] IAXI_addr = '0;
  logic [31:0] IAXI_read_data;
  logic        IAXI_read_data_valid;
  logic        IAXI_bus_error;
  logic        M_ARVALID;
  logic        M_ARREADY = 1'b0;
  logic [31:0] M_ARADDR;
  logic [3:0]  M_ARID;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic [2:0]  M_ARPROT;
  logic        M_RVALID = 1'b0;
  logic        M_RREADY;
  logic [31:0] M_RDATA = '0;
  logic [3:0]  M_RID = '0;
  logic [1:0]  M_RRESP = '0;
  logic        M_RLAST = 1'b1;

  iaxi_fetch_bridge dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .IAXI_access(IAXI_access), .IAXI_addr(IAXI_addr),
    .IAXI_read_data(IAXI_read_data), .IAXI_read_data_valid(IAXI_read_data_valid),
    .IAXI_bus_error(IAXI_bus_error),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
    .M_ARID(M_ARID), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARPROT(M_ARPROT),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RID(M_RID),
    .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
  );

  always #5 cpu_clk = ~cpu_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one fetch record {addr, address phase done, abandoned}.
  bit          m_busy, m_ar_done, m_drop, m_pulse, m_err, nxt_pulse;
  logic [31:0] m_addr, m_data;

  always @(negedge cpu_clk) begin
    if (cpu_rst) begin
      m_busy = 0; m_ar_done = 0; m_drop = 0; m_pulse = 0; m_err = 0;
      m_addr = '0; m_data = '0;
    end
    chk("arvalid", M_ARVALID, m_busy && !m_ar_done);
    chk("rready", M_RREADY, m_busy && m_ar_done);
    if (cpu_rst || (m_busy && !m_ar_done)) chk("araddr", M_ARADDR, m_addr);
    if (m_busy && !m_ar_done)
      chk("ar_consts", {M_ARID, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT},
          {4'h0, 8'h00, 3'b010, 2'b01, 3'b100});
    chk("valid", IAXI_read_data_valid, m_pulse);
    chk("bus_error", IAXI_bus_error, m_pulse && m_err);
    chk("read_data", IAXI_read_data, m_data);
    if (!cpu_rst) begin
      nxt_pulse = 0;
      if (!m_busy) begin
        if (IAXI_access && !m_pulse) begin
          m_busy = 1; m_ar_done = 0; m_drop = 0;
          m_addr = IAXI_addr & 32'hFFFF_FFFC;
        end
      end else begin
        if (!IAXI_access || ((IAXI_addr & 32'hFFFF_FFFC) != m_addr)) m_drop = 1;
        if (!m_ar_done) m_ar_done = M_ARREADY;
        else if (M_RVALID) begin
          m_busy = 0;
          if (!m_drop) begin
            nxt_pulse = 1;
            m_data = M_RDATA;
            m_err = (M_RRESP != 2'b00) || (M_RID != 4'h0) || !M_RLAST;
          end
        end
      end
      m_pulse = nxt_pulse;
    end
  end

  bit          rand_mode = 0;
  bit          pending = 0;
  int          delay = 0;
  int          cfg_delay = 2;
  logic [31:0] cfg_data = '0;
  logic [1:0]  cfg_resp = '0;

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 32'h0000_1004;
      1: return 32'h0000_1006;
      2: return 32'h0000_2000;
      default: return $urandom;
    endcase
  endfunction

  // Advance one clock: interconnect responder plus (in random mode) the fetch unit.
  task automatic step();
    bit ar_hs, r_hs;
    ar_hs = M_ARVALID && M_ARREADY;
    r_hs  = M_RVALID && M_RREADY;
    @(posedge cpu_clk); #1;
    if (r_hs) pending = 0;
    if (ar_hs) begin
      pending = 1;
      if (rand_mode) begin
        delay   = $urandom_range(0, 4);
        M_RDATA = $urandom;
        M_RRESP = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        M_RID   = ($urandom_range(0, 9) == 0) ? 4'h3 : 4'h0;
        M_RLAST = ($urandom_range(0, 9) != 0);
      end else begin
        delay = cfg_delay; M_RDATA = cfg_data; M_RRESP = cfg_resp; M_RID = 4'h0; M_RLAST = 1'b1;
      end
    end
    if (pending) begin
      if (delay > 0) begin delay--; M_RVALID = 1'b0; end
      else M_RVALID = 1'b1;
    end else begin
      M_RVALID = rand_mode && ($urandom_range(0, 7) == 0);
      if (M_RVALID) M_RDATA = $urandom;
    end
    if (rand_mode) begin
      M_ARREADY = 1'($urandom_range(0, 1));
      if (IAXI_read_data_valid) begin
        IAXI_access = 1'($urandom_range(0, 1));
        IAXI_addr   = pick_addr();
      end else if (!IAXI_access) begin
        if ($urandom_range(0, 2) == 0) begin IAXI_access = 1'b1; IAXI_addr = pick_addr(); end
      end else if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) IAXI_access = 1'b0;
        else IAXI_addr = pick_addr();
      end
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                          input int hold, input bit redir, input logic [31:0] ra,
                          input logic [31:0] rd,
                          output logic [31:0] first_araddr, output logic [31:0] last_araddr,
                          output int pulses, output logic [31:0] got_data, output logic got_err,
                          output int arv_cycles, output bit stable);
    int  hcnt = 0;
    int  after = -1;
    bit  seen_ar = 0;
    bit  redirected = 0;
    bit  prev_arv = 0;
    cfg_data = d; cfg_resp = resp;
    IAXI_access = 1'b1; IAXI_addr = a; M_ARREADY = 1'b0;
    pulses = 0; arv_cycles = 0; stable = 1;
    first_araddr = '0; last_araddr = '0; got_data = '0; got_err = 1'b0;
    for (int cyc = 0; cyc < 60 && after != 0; cyc++) begin
      step();
      if (M_ARVALID) begin
        if (!seen_ar) first_araddr = M_ARADDR;
        if (prev_arv && M_ARADDR != last_araddr) stable = 0;
        seen_ar = 1;
        last_araddr = M_ARADDR;
        arv_cycles++;
      end
      prev_arv  = M_ARVALID;
      M_ARREADY = M_ARVALID && (hcnt >= hold);
      hcnt      = M_ARVALID ? hcnt + 1 : 0;
      if (redir && !redirected && M_RREADY) begin
        IAXI_addr = ra; cfg_data = rd; redirected = 1;
      end
      if (IAXI_read_data_valid) begin
        pulses++; got_data = IAXI_read_data; got_err = IAXI_bus_error;
        IAXI_access = 1'b0; after = 3;
      end else if (after > 0) begin
        after--;
      end
    end
    M_ARREADY = 1'b0;
  endtask

  logic [31:0] fa, la, gd;
  logic        ge;
  int          np, ac;
  bit          st;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("rst_arvalid", M_ARVALID, 1'b0);
    chk("rst_rready", M_RREADY, 1'b0);
    chk("rst_araddr", M_ARADDR, 32'h0);
    chk("rst_data", IAXI_read_data, 32'h0);
    chk("rst_valid", IAXI_read_data_valid, 1'b0);
    chk("rst_err", IAXI_bus_error, 1'b0);
    cpu_rst = 1'b0;
    step();

    cfg_delay = 2;
    do_fetch(32'h0000_1004, 32'h00A0_0093, 2'b00, 0, 0, '0, '0, fa, la, np, gd, ge, ac, st);
    chk("t1_araddr", fa, 32'h0000_1004);
    chk("t1_pulses", np, 1);
    chk("t1_data", gd, 32'h00A0_0093);
    chk("t1_err", ge, 1'b0);

    do_fetch(32'h0000_3008, 32'h1234_5678, 2'b00, 5, 0, '0, '0, fa, la, np, gd, ge, ac, st);
    chk("t2_arvalid_cycles", ac, 6);
    chk("t2_stable", st, 1'b1);
    chk("t2_pulses", np, 1);
    chk("t2_data", gd, 32'h1234_5678);

    cfg_delay = 3;
    do_fetch(32'h0000_1004, 32'h1111_1111, 2'b00, 0, 1, 32'h0000_2000, 32'h2222_2222,
             fa, la, np, gd, ge, ac, st);
    chk("t3_first_araddr", fa, 32'h0000_1004);
    chk("t3_second_araddr", la, 32'h0000_2000);
    chk("t3_pulses", np, 1);
    chk("t3_data", gd, 32'h2222_2222);

    cfg_delay = 1;
    do_fetch(32'h0000_0040, 32'hDEAD_BEEF, 2'b10, 1, 0, '0, '0, fa, la, np, gd, ge, ac, st);
    chk("t4_pulses", np, 1);
    chk("t4_err", ge, 1'b1);
    chk("t4_data", gd, 32'hDEAD_BEEF);

    cfg_resp = 2'b00;
    do_fetch(32'h0000_1006, 32'hCAFE_0001, 2'b00, 0, 0, '0, '0, fa, la, np, gd, ge, ac, st);
    chk("t5_araddr", fa, 32'h0000_1004);
    chk("t5_data", gd, 32'hCAFE_0001);

    IAXI_access = 1'b1; IAXI_addr = 32'h0000_5000; M_ARREADY = 1'b0;
    step();
    step();
    chk("t6_in_ar", M_ARVALID, 1'b1);
    #2 cpu_rst = 1'b1;
    #1;
    chk("t6_arvalid_async", M_ARVALID, 1'b0);
    chk("t6_valid_async", IAXI_read_data_valid, 1'b0);
    chk("t6_rready_async", M_RREADY, 1'b0);
    IAXI_access = 1'b0; pending = 0; M_RVALID = 1'b0;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    step();
    chk("t6_idle_after", M_ARVALID, 1'b0);

    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0;
    IAXI_access = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
